// File: rtl/assoc_cache_if.sv
// CPU-side and memory-side signal bundle for assoc_cache.
// The CPU presents a request with input_ready=1 and must hold addr/w_en/write_data
// until it samples hit=1; the access completes on that posedge. The memory side has no
// handshake: mread_data follows maddr combinationally and m_wen writes on the posedge.
interface assoc_cache_if;
  logic        stall;
  logic        input_ready;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        w_en;
  logic        hit;
  logic [31:0] read_data;
  logic [31:0] maddr;
  logic [31:0] mwrite_data;
  logic        m_wen;
  logic [31:0] mread_data;

  modport master (
    output stall, input_ready, addr, write_data, w_en, mread_data,
    input  hit, read_data, maddr, mwrite_data, m_wen
  );

  modport slave (
    input  stall, input_ready, addr, write_data, w_en, mread_data,
    output hit, read_data, maddr, mwrite_data, m_wen
  );
endinterface

// File: rtl/assoc_cache.sv
// 2-way set-associative, write-back, write-allocate cache with true-LRU replacement.
// A miss runs an optional line writeback followed by a line refill, one word per cycle.
module assoc_cache #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic         clk,
  input  logic         reset,
  assoc_cache_if.slave bus,
  output logic [1:0]   state_dbg
);
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2} state_t;

  state_t state_q, state_d;

  logic [1:0]          valid_q [SETS];
  logic [1:0]          dirty_q [SETS];
  logic [SETS-1:0]     lru_q;
  logic [TAG_BITS-1:0] tag_q   [SETS][2];
  logic [31:0]         data_q  [SETS][2][WORDS];

  // Miss context, captured when the miss is detected
  logic                   victim_q;
  logic [TAG_BITS-1:0]    req_tag_q;
  logic [INDEX_BITS-1:0]  idx_q;
  logic [OFFSET_BITS-1:0] cnt_q;

  logic [OFFSET_BITS-1:0] word_sel;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic [1:0]             way_hit;
  logic                   hit_way;
  logic                   victim;
  logic                   miss;
  logic                   last;
  logic                   unused_bits;

  assign word_sel    = bus.addr[OFFSET_BITS+1:2];
  assign index       = bus.addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign tag         = bus.addr[31 -: TAG_BITS];
  assign unused_bits = ^{bus.stall, bus.addr[1:0]};

  assign way_hit[0] = valid_q[index][0] && (tag_q[index][0] == tag);
  assign way_hit[1] = valid_q[index][1] && (tag_q[index][1] == tag);
  assign hit_way    = ~way_hit[0];
  assign victim     = !valid_q[index][0] ? 1'b0 :
                      !valid_q[index][1] ? 1'b1 : lru_q[index];
  assign miss       = (state_q == IDLE) && bus.input_ready && !(|way_hit);
  assign last       = &cnt_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss) state_d = (valid_q[index][victim] && dirty_q[index][victim])
                                     ? WRITEBACK : REFILL;
      WRITEBACK: if (last) state_d = REFILL;
      REFILL:    if (last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.hit         = 1'b0;
    bus.read_data   = '0;
    bus.maddr       = '0;
    bus.mwrite_data = '0;
    bus.m_wen       = 1'b0;
    case (state_q)
      IDLE: begin
        bus.hit       = ~bus.input_ready | (|way_hit);
        bus.read_data = way_hit[0] ? data_q[index][0][word_sel] :
                        way_hit[1] ? data_q[index][1][word_sel] : 32'd0;
      end
      WRITEBACK: begin
        bus.m_wen       = 1'b1;
        bus.maddr       = {tag_q[idx_q][victim_q], idx_q, cnt_q, 2'b00};
        bus.mwrite_data = data_q[idx_q][victim_q][cnt_q];
      end
      REFILL: bus.maddr = {req_tag_q, idx_q, cnt_q, 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      lru_q     <= '0;
      victim_q  <= 1'b0;
      req_tag_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.input_ready && (|way_hit)) begin
            lru_q[index] <= ~hit_way;
            if (bus.w_en) dirty_q[index][hit_way] <= 1'b1;
          end else if (miss) begin
            victim_q  <= victim;
            req_tag_q <= tag;
            idx_q     <= index;
            cnt_q     <= '0;
          end
        end
        WRITEBACK: cnt_q <= cnt_q + 1'b1;
        REFILL: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            valid_q[idx_q][victim_q] <= 1'b1;
            dirty_q[idx_q][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: valid bits guard every read
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.input_ready && bus.w_en && (|way_hit))
      data_q[index][hit_way][word_sel] <= bus.write_data;
    if (state_q == REFILL) begin
      data_q[idx_q][victim_q][cnt_q] <= bus.mread_data;
      if (last) tag_q[idx_q][victim_q] <= req_tag_q;
    end
  end
endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache: vector table of CPU accesses plus hand-written
// dirty-eviction and mid-refill reset sequences, against a word-wide memory model.
module tb_assoc_cache;
  localparam int WORDS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_init;
  logic [1:0] state_dbg;
  int         tests = 0;
  int         fails = 0;

  assoc_cache_if bus();

  assoc_cache #(.INDEX_BITS(3), .OFFSET_BITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h11 : 32'h100 + 32'(i);
  endfunction

  logic [31:0] mem [0:255];
  assign bus.mread_data = mem[bus.maddr[9:2]];

  always @(posedge clk or posedge mem_init) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else if (bus.m_wen) mem[bus.maddr[9:2]] <= bus.mwrite_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: read data per access, and {maddr, mwrite_data} per memory write
  logic [31:0] exp_q[$];
  logic [63:0] wb_q[$];
  logic [32:0] log_q[$];

  always @(negedge clk) begin
    #2;
    if (!reset && bus.m_wen === 1'b1) begin
      if (wb_q.size() == 0) check("unexpected_mwrite", {bus.maddr, bus.mwrite_data}, 64'd0);
      else check("mwrite", {bus.maddr, bus.mwrite_data}, wb_q.pop_front());
    end
  end

  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [31:0] exp_rd, output int n);
    logic [31:0] exp;
    exp_q.push_back(exp_rd);
    log_q.delete();
    @(negedge clk);
    bus.addr = a; bus.w_en = we; bus.write_data = wd; bus.input_ready = 1'b1;
    n = 0;
    #1;
    while (!bus.hit && n < 50) begin
      log_q.push_back({bus.m_wen, bus.maddr});
      n++;
      @(negedge clk);
      #1;
    end
    exp = exp_q.pop_front();
    check("read_data", bus.read_data, exp);
    @(posedge clk);
    #1;
    bus.input_ready = 1'b0;
    bus.w_en = 1'b0;
  endtask

  task automatic check_log(input logic [31:0] a, input logic dirty, input logic [31:0] wb_base);
    int n;
    int rf0;
    n   = dirty ? 1 + 2 * WORDS : 1 + WORDS;
    rf0 = dirty ? 1 + WORDS : 1;
    check("log_len", 64'(log_q.size()), 64'(n));
    if (log_q.size() == n) begin
      check("log_detect", 64'(log_q[0]), 64'd0);
      for (int k = 0; k < WORDS; k++) begin
        if (dirty) check("log_wb", 64'(log_q[1+k]), 64'({1'b1, wb_base + 32'(4*k)}));
        check("log_refill", 64'(log_q[rf0+k]), 64'({1'b0, (a & ~32'hF) + 32'(4*k)}));
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          cyc;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n;
    vecs[0]  = '{32'h000, 1'b0, 32'h0,    5, 32'h11};
    vecs[1]  = '{32'h008, 1'b0, 32'h0,    0, 32'h102};
    vecs[2]  = '{32'h004, 1'b1, 32'hDEAD, 0, 32'h101};
    vecs[3]  = '{32'h004, 1'b0, 32'h0,    0, 32'hDEAD};
    vecs[4]  = '{32'h080, 1'b0, 32'h0,    5, 32'h120};
    vecs[5]  = '{32'h000, 1'b0, 32'h0,    0, 32'h11};
    vecs[6]  = '{32'h100, 1'b0, 32'h0,    5, 32'h140};
    vecs[7]  = '{32'h000, 1'b0, 32'h0,    0, 32'h11};
    vecs[8]  = '{32'h080, 1'b0, 32'h0,    5, 32'h120};
    vecs[9]  = '{32'h000, 1'b1, 32'hAA,   0, 32'h11};
    vecs[10] = '{32'h084, 1'b0, 32'h0,    0, 32'h121};

    // Clock/reset
    reset = 1'b1; mem_init = 1'b1;
    bus.stall = 1'b0; bus.input_ready = 1'b0; bus.w_en = 1'b0;
    bus.addr = '0; bus.write_data = '0;
    #1 mem_init = 1'b0;
    #2;
    check("rst_hit", 64'(bus.hit), 64'd1);
    check("rst_m_wen", 64'(bus.m_wen), 64'd0);
    check("rst_maddr", 64'(bus.maddr), 64'd0);
    check("rst_mwrite_data", 64'(bus.mwrite_data), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      access(vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].rd, n);
      check($sformatf("cycles_v%0d", i), 64'(n), 64'(vecs[i].cyc));
      if (vecs[i].cyc != 0) check_log(vecs[i].addr, 1'b0, 32'd0);
    end
    @(negedge clk);
    check("mem1_unchanged", 64'(mem[1]), 64'h101);
    check("mem0_unchanged", 64'(mem[0]), 64'h11);

    // Dirty eviction of the 0x000 line by 0x100
    wb_q.push_back({32'h000, 32'hAA});
    wb_q.push_back({32'h004, 32'hDEAD});
    wb_q.push_back({32'h008, 32'h102});
    wb_q.push_back({32'h00C, 32'h103});
    access(32'h100, 1'b0, 32'h0, 32'h140, n);
    check("cycles_dirty", 64'(n), 64'd9);
    check_log(32'h100, 1'b1, 32'h000);
    @(negedge clk);
    check("mem0_wb", 64'(mem[0]), 64'hAA);
    check("mem1_wb", 64'(mem[1]), 64'hDEAD);
    check("wb_drained", 64'(wb_q.size()), 64'd0);

    // Reset during the second refill cycle
    @(negedge clk);
    bus.addr = 32'h040; bus.w_en = 1'b0; bus.input_ready = 1'b1;
    #1 check("mid_miss_hit", 64'(bus.hit), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 check("mid_refill_maddr", 64'(bus.maddr), 64'h044);
    reset = 1'b1;
    #1;
    check("mid_rst_hit", 64'(bus.hit), 64'd0);
    check("mid_rst_maddr", 64'(bus.maddr), 64'd0);
    check("mid_rst_m_wen", 64'(bus.m_wen), 64'd0);
    check("mid_rst_mwrite_data", 64'(bus.mwrite_data), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'd0);
    bus.input_ready = 1'b0;
    #1 check("mid_rst_idle_hit", 64'(bus.hit), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    access(32'h040, 1'b0, 32'h0, 32'h110, n);
    check("cycles_after_rst", 64'(n), 64'd5);
    check_log(32'h040, 1'b0, 32'd0);
    access(32'h100, 1'b0, 32'h0, 32'h140, n);
    check("cycles_flushed", 64'(n), 64'd5);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- 2-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Drop-in sibling of the direct-mapped cache: one instance sits between the mips core and imem (I-side), another between the core and dmem (D-side).
- Memory side is word-wide: reads are combinational, writes are synchronous.
- Multi-cycle refill/writeback FSM; CPU-side `hit` feeds the global stall equation.

Parameters:
- INDEX_BITS, 3, log2 number of sets (default 8 sets).
- OFFSET_BITS, 2, log2 words per line (default 4 words/line).
- Fixed: 2 ways, 32-bit data, 32-bit byte address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  global pipeline stall (informational; does not gate the FSM).
- input_ready  in  1  CPU access valid this cycle.
- addr  in  32  CPU byte address.
- write_data  in  32  CPU store data.
- w_en  in  1  CPU store request.
- hit  out  1  access satisfied this cycle.
- read_data  out  32  CPU load/fetch data.
- maddr  out  32  memory byte address (word-aligned).
- mwrite_data  out  32  memory store data.
- m_wen  out  1  memory write enable.
- mread_data  in  32  memory read data, combinational on maddr.

Behaviour:
- Address split: [1:0] ignored; word = [OFFSET_BITS+1:2]; index = next INDEX_BITS; tag = remaining upper bits.
- Per set: valid[2], dirty[2], tag[2], data[2][words], lru (1 bit = way to evict next).
- Reset (async):
  - All valid, dirty and lru bits = 0; state = IDLE.
  - Outputs: m_wen = 0, maddr = 0, mwrite_data = 0, hit = ~input_ready.
  - A refill or writeback in flight is abandoned; the line is left invalid.
- States: IDLE, WRITEBACK, REFILL.
- IDLE:
  - hit = ~input_ready | (valid & tag match in either way), combinational.
  - read_data = matching way's word, combinational; 0 on miss.
  - Read hit: lru <= other way at posedge.
  - Write hit: word <= write_data, dirty <= 1, lru <= other way at posedge. Repeated posedges with the same write while stalled are idempotent and permitted.
  - Miss: victim = invalid way if any (way0 preferred), else the lru way. Victim valid & dirty -> WRITEBACK, else -> REFILL; counter <= 0.
- WRITEBACK:
  - m_wen = 1; maddr = {victim tag, index, counter, 2'b00}; mwrite_data = victim word[counter].
  - Counter increments each cycle; after the last word, -> REFILL with counter <= 0.
  - hit = 0.
- REFILL:
  - m_wen = 0; maddr = {req tag, index, counter, 2'b00}.
  - Each posedge writes victim word[counter] <= mread_data.
  - After the last word: tag <= req tag, valid <= 1, dirty <= 0; -> IDLE. hit = 0.
  - The access re-evaluates in IDLE the next cycle and hits; any pending write applies then.
- Miss latency: 2^OFFSET_BITS refill cycles + 1 (clean victim); add 2^OFFSET_BITS writeback cycles if the victim is dirty.
- The request (addr, w_en) must stay stable while hit = 0; the global stall guarantees this. The victim way and request tag are latched at miss detection regardless.
- input_ready dropping mid-miss: the FSM completes the miss anyway.
- With w_en tied 0 (I-side), m_wen never asserts: lines are never dirty.

Test Plan:
- Reset, read 0x00 (mem word0 = 0x11) -> hit = 0 for 5 cycles, maddr steps 0x0, 0x4, 0x8, 0xC; then hit = 1, read_data = 0x11. Read 0x8 next -> immediate hit, no memory traffic.
- Write 0x4 = 0xDEAD after line fill -> hit same cycle, m_wen stays 0, dmem[1] unchanged; read 0x4 -> 0xDEAD.
- Conflict set 0 (default params: 0x000, 0x080, 0x100):
  - Read 0x000, 0x080 -> both resident.
  - Read 0x000 again, then 0x100 -> evicts 0x080 way (LRU).
  - Read 0x000 -> hit.
- Dirty eviction:
  - Write 0x000 = 0xAA; fill 0x080; touch 0x080.
  - Access 0x100 -> 4 writeback cycles with m_wen = 1, maddr 0x000..0x00C, first mwrite_data = 0xAA, then 4 refill cycles.
  - dmem[0] = 0xAA afterwards.
- Assert reset during the 2nd refill cycle -> all outputs return to reset values immediately; the subsequent read of the same address performs a full 4-cycle refill.
- Full benchmark suite with both caches replaced by assoc_cache -> all runtime and memory checks pass; record CPI versus the direct-mapped baseline.
